dds_wave_gen: RTL

Parametrised successor to the single-rate DDS output stage. It steps a waveform-ROM address by a programmable stride at a programmable sample rate, wrapping modulo a non-power-of-two table depth. It absorbs ROM read latency, holds the DAC word between samples, and generates the ADC sample clock aligned to each sample. It sits between the waveform ROM and the DAC/ADC pins. Rate and stride are updated glitch-free through a valid/ready handshake.

---
 rtl/dds_pkg.sv | 20 ++
 rtl/dds_rate_div.sv | 60 ++++++
 rtl/dds_wave_gen.sv | 128 ++++++++++++
 3 files changed

// File: rtl/dds_pkg.sv
// Shared constants and helpers for the DDS waveform generator.
package dds_pkg;

  localparam int unsigned DDS_ADDR_W  = 11;
  localparam int unsigned DDS_DATA_W  = 14;
  localparam int unsigned DDS_DIV_W   = 24;
  localparam int unsigned DDS_DEPTH   = 2000;
  localparam int unsigned DDS_ROM_LAT = 1;
  localparam int unsigned DDS_DEF_DIV = 99;

  // Strides at or beyond the table depth are folded to the largest legal stride.
  function automatic int unsigned clamp_step(input int unsigned step, input int unsigned depth);
    return (step >= depth) ? depth - 32'd1 : step;
  endfunction

  function automatic int unsigned half_period(input int unsigned d);
    return (d + 32'd1) >> 1;
  endfunction

endpackage

// File: rtl/dds_rate_div.sv
// Sample-rate divider: period counter, sample tick and registered ADC clock.
module dds_rate_div
  import dds_pkg::*;
#(
  parameter int unsigned DIV_W   = DDS_DIV_W,
  parameter int unsigned DEF_DIV = DDS_DEF_DIV
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             apply_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_c_o,
  output logic             adc_clock_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             adc_q, adc_d;
  logic             set_adc_c;

  assign tick_c_o  = en_i && (cnt_q == div_q);
  assign set_adc_c = (div_q != '0) && (32'(cnt_q) == half_period(32'(div_q)) - 32'd1);

  always_comb begin
    cnt_d = cnt_q;
    div_d = div_q;
    adc_d = adc_q;
    if (!en_i || tick_c_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
    // A new rate always starts a fresh period.
    if (apply_i) begin
      div_d = div_i;
      cnt_d = '0;
    end
    if (!en_i || tick_c_o) begin
      adc_d = 1'b0;
    end else if (set_adc_c) begin
      adc_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      div_q <= DIV_W'(DEF_DIV);
      adc_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
      adc_q <= adc_d;
    end
  end

  assign adc_clock_o = adc_q;

endmodule

// File: rtl/dds_wave_gen.sv
// DDS output stage: strided ROM addressing with modulo-DEPTH wrap, ROM latency
// alignment, held DAC word and a glitch-free rate/stride update handshake.
module dds_wave_gen
  import dds_pkg::*;
#(
  parameter int unsigned ADDR_W  = DDS_ADDR_W,
  parameter int unsigned DATA_W  = DDS_DATA_W,
  parameter int unsigned DIV_W   = DDS_DIV_W,
  parameter int unsigned DEPTH   = DDS_DEPTH,
  parameter int unsigned ROM_LAT = DDS_ROM_LAT,
  parameter int unsigned DEF_DIV = DDS_DEF_DIV
) (
  input  logic              clk_400M,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [ADDR_W-1:0] cfg_step,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_q,
  output logic [DATA_W-1:0] dac_data,
  output logic              dac_valid,
  output logic              adc_clock,
  output logic              wrap_pulse
);

  localparam int unsigned SUM_W = ADDR_W + 1;

  logic               tick_c, apply_c, accept_c;
  logic [SUM_W-1:0]   sum_c;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W-1:0]  step_q, step_d;
  logic [ADDR_W-1:0]  sh_step_q, sh_step_d;
  logic [DIV_W-1:0]   sh_div_q, sh_div_d;
  logic               pend_q, pend_d;
  logic               ready_q, ready_d;
  logic               wrap_q, wrap_d;
  logic [ROM_LAT-1:0] lat_q, lat_d;
  logic [DATA_W-1:0]  dac_q, dac_d;
  logic               dval_q, dval_d;

  assign accept_c = cfg_valid && ready_q;
  // Pending config lands on the next tick, or immediately when idle.
  assign apply_c  = pend_q && (tick_c || !en);
  assign sum_c    = SUM_W'(addr_q) + SUM_W'(step_q);

  dds_rate_div #(
    .DIV_W  (DIV_W),
    .DEF_DIV(DEF_DIV)
  ) u_rate_div (
    .clk        (clk_400M),
    .rst_n      (rst_n),
    .en_i       (en),
    .apply_i    (apply_c),
    .div_i      (sh_div_q),
    .tick_c_o   (tick_c),
    .adc_clock_o(adc_clock)
  );

  always_comb begin
    addr_d    = addr_q;
    step_d    = step_q;
    sh_step_d = sh_step_q;
    sh_div_d  = sh_div_q;
    pend_d    = pend_q;
    ready_d   = ready_q;
    wrap_d    = 1'b0;
    dac_d     = dac_q;
    lat_d     = ROM_LAT'({lat_q, tick_c});
    dval_d    = lat_q[ROM_LAT-1];
    if (tick_c) begin
      if (sum_c >= SUM_W'(DEPTH)) begin
        addr_d = ADDR_W'(sum_c - SUM_W'(DEPTH));
        wrap_d = 1'b1;
      end else begin
        addr_d = ADDR_W'(sum_c);
      end
    end
    if (lat_q[ROM_LAT-1]) begin
      dac_d = rom_q;
    end
    if (apply_c) begin
      step_d  = sh_step_q;
      pend_d  = 1'b0;
      ready_d = 1'b1;
    end
    if (accept_c) begin
      sh_div_d  = cfg_div;
      sh_step_d = ADDR_W'(clamp_step(32'(cfg_step), DEPTH));
      pend_d    = 1'b1;
      ready_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_400M or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      step_q    <= ADDR_W'(1);
      sh_step_q <= ADDR_W'(1);
      sh_div_q  <= DIV_W'(DEF_DIV);
      pend_q    <= 1'b0;
      ready_q   <= 1'b1;
      wrap_q    <= 1'b0;
      lat_q     <= '0;
      dac_q     <= '0;
      dval_q    <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      step_q    <= step_d;
      sh_step_q <= sh_step_d;
      sh_div_q  <= sh_div_d;
      pend_q    <= pend_d;
      ready_q   <= ready_d;
      wrap_q    <= wrap_d;
      lat_q     <= lat_d;
      dac_q     <= dac_d;
      dval_q    <= dval_d;
    end
  end

  assign rom_addr   = addr_q;
  assign cfg_ready  = ready_q;
  assign wrap_pulse = wrap_q;
  assign dac_data   = dac_q;
  assign dac_valid  = dval_q;

endmodule
